// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - E-stage multiply/divide sequencer owning HI/LO.
// Optional MDU_SEQ_ABORT_EN adds an abort input that cancels or blocks ops.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_op,
  input  logic        e_kill,
`ifdef MDU_SEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic [31:0] e_src_a,
  input  logic [31:0] e_src_b,
  input  logic        d_md,
  input  logic        d_mf,
  input  logic        d_mt,
  output logic        start,
  output logic        busy,
  output logic        stall_mdu,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ovr_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        abort_i;
  logic        op_ok;
  logic        is_md;
  logic        is_ctl;

`ifdef MDU_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign op_ok     = !e_kill && !abort_i;
  assign is_md     = (e_op >= OP_MULT) && (e_op <= OP_DIVU);
  assign is_ctl    = (e_op >= OP_MULT) && (e_op <= OP_MTLO);
  assign start     = op_ok && is_md && (state == IDLE);
  assign stall_mdu = start | (busy & (d_md | d_mf | d_mt));

  // Signed divide goes through magnitudes so 0x80000000 / -1 needs no special case.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        commit_en;

  always_comb begin
    prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    div_signed = (op_q == OP_DIV);
    a_mag      = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag      = b_q[31] ? (32'd0 - b_q) : b_q;
    dvd        = div_signed ? a_mag : a_q;
    dvs        = div_signed ? b_mag : b_q;
    if (dvs == 32'd0) begin
      dvs = 32'd1;
    end
    q_mag      = dvd / dvs;
    r_mag      = dvd % dvs;
    commit_en  = 1'b1;
    res_hi     = hi;
    res_lo     = lo;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo    = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
        res_hi    = a_q[31] ? (32'd0 - r_mag) : r_mag;
        commit_en = (b_q != 32'd0);
      end
      OP_DIVU: begin
        res_lo    = q_mag;
        res_hi    = r_mag;
        commit_en = (b_q != 32'd0);
      end
      default: commit_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      ovr_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= e_op;
            a_q   <= e_src_a;
            b_q   <= e_src_b;
            cnt   <= (e_op <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            busy  <= 1'b1;
            state <= RUN;
          end else if (op_ok && e_op == OP_MTHI) begin
            hi <= e_src_a;
          end else if (op_ok && e_op == OP_MTLO) begin
            lo <= e_src_a;
          end
        end
        RUN: begin
          if (!e_kill && is_ctl) begin
            ovr_err <= 1'b1;
          end
          if (abort_i) begin
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            if (commit_en) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Controls the E-stage multiply/divide resource: accepts MDU ops from the E stage and latches their operands.
- Runs a fixed-latency countdown and commits results to the architectural HI/LO registers.
- Drives the start/busy/stall signals used by the hazard unit to hold md/mf/mt instructions in D.
- Owns HI/LO; the E/M/W datapath reads hi/lo for mfhi/mflo forwarding.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy duration for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- e_op  input  4  E-stage MDU op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as none.
- e_kill  input  1  E-stage instruction is squashed; its op is ignored.
- e_src_a  input  32  forwarded rs value.
- e_src_b  input  32  forwarded rt value.
- d_md  input  1  D-stage holds mult/multu/div/divu.
- d_mf  input  1  D-stage holds mfhi/mflo.
- d_mt  input  1  D-stage holds mthi/mtlo.
- start  output  1  combinational: e_op in 1..4, e_kill=0, state IDLE.
- busy  output  1  registered: operation in flight.
- stall_mdu  output  1  combinational: start | (busy & (d_md | d_mf | d_mt)).
- hi  output  32  registered HI.
- lo  output  32  registered LO.
- ovr_err  output  1  sticky: an op in 1..6 arrived while busy.

Behaviour:
- Reset (reset=0, async): state IDLE, busy=0, hi=0, lo=0, ovr_err=0, counter=0, operand/op latches=0. start and stall_mdu are then 0 unless e_op/d_* force start.
- States: IDLE, RUN.
- IDLE, start=1 at edge t:
  - latch op, e_src_a, e_src_b.
  - load counter with MULT_CYCLES or DIV_CYCLES.
  - go to RUN; busy=1 from t+1.
- RUN, each edge: counter decrements.
  - On the edge where counter==1: commit results to HI/LO, busy->0, state->IDLE.
  - busy is therefore high for exactly N cycles; new HI/LO are visible the same cycle busy falls.
- Results:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (latched b==0): hi/lo unchanged at commit; the busy timing is unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- mthi/mtlo (op 5/6), IDLE, not killed: hi (or lo) <= e_src_a at that edge, single cycle; busy and start stay 0.
- Ops 1..6 arriving in RUN (only possible if the hazard logic failed) are ignored and set ovr_err; the in-flight op continues.
- mfhi/mflo (7/8) and none: no state change; hi/lo are held.
- e_kill=1: e_op is treated as none that cycle, including start.
- The dividend/divisor used are the latched values; changes on e_src_* during RUN have no effect.

Optional Feature:
- Macro MDU_SEQ_ABORT_EN.
- When defined:
  - adds input port abort (1 bit, placed after e_kill).
  - abort=1 in RUN: at the next edge go to IDLE, busy=0, no HI/LO commit.
  - abort=1 in IDLE blocks start (start forced 0) and blocks mthi/mtlo writes that cycle.
  - abort coinciding with the commit edge: the abort wins, and no commit happens.
- When undefined: the port is absent and every started op always commits.

Test Plan:
- Reset release, then multu a=0xFFFFFFFF b=2 -> start=1 one cycle, busy=1 for exactly 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
- mult a=0xFFFFFFFF b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE after 5 busy cycles; div a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload hi=0x1234 via mthi, then divu a=7 b=0 -> busy 10 cycles, hi stays 0x00001234, lo unchanged; then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- During busy, assert d_mf=1 -> stall_mdu=1 every busy cycle and 0 on the cycle busy falls; d_md=d_mf=d_mt=0 during busy -> stall_mdu=0.
- Drive e_op=1 with e_kill=1 -> start=0, busy stays 0, ovr_err=0; force e_op=3 while busy -> ovr_err=1 and the original result is still committed.
- Pull reset low at busy cycle 3 of a mult -> busy, hi and lo read 0 immediately (before the next clock edge); after reset release, mtlo a=0xA5A5A5A5 -> lo=0xA5A5A5A5 next cycle.
